// File: rtl/pwm_duty_sequencer.sv
// pwm_duty_sequencer
// Control block for the PWM channel bank. It decodes address/duty packets
// from the SPI receiver, holds a target duty per channel, ramps each live
// duty toward its target on PWM period boundaries, owns the shared 8-bit
// period counter, and drives the registered comparator outputs. A
// period-based watchdog falls back to a failsafe pattern (vent channel full
// on, all others off) when the SPI master goes silent.

module pwm_duty_sequencer #(
  parameter int          NUM_CH      = 4,
  parameter int          STEP        = 1,
  parameter int          RAMP_DIV    = 1,
  parameter logic [15:0] WDT_PERIODS = 16'd6104,
  parameter int          VENT_CH     = 0
) (
  input  logic                  clk25M,
  input  logic                  rst_n,
  input  logic [15:0]           byte_data_received,
  input  logic                  SSEL,
  output logic [7:0]            pwm_cnt,
  output logic [8*NUM_CH-1:0]   duty_cur,
  output logic [NUM_CH-1:0]     pwm_out,
  output logic                  wdt_tripped,
  output logic                  pkt_err
);

  // Last divider value; the step fires on the period tick that sees it.
  localparam logic [7:0]  DIV_LAST = 8'(RAMP_DIV - 1);
  // Step size widened so difference comparisons never truncate.
  localparam logic [8:0]  STEP9    = 9'(STEP);
  localparam logic [7:0]  ADDR_ALL = 8'hFF;
  localparam logic [7:0]  ADDR_MAX = 8'(NUM_CH);
  localparam logic        WDT_EN   = (WDT_PERIODS != 16'd0);
  localparam logic [15:0] WDT_LAST = WDT_PERIODS - 16'd1;

  // Packet capture and decode.
  logic        ssel_meta;
  logic        ssel_sync;
  logic        ssel_dly;
  logic        pkt_evt;
  logic [7:0]  pkt_addr;
  logic [7:0]  pkt_duty;
  logic        addr_is_ch;
  logic        addr_is_all;
  logic        pkt_valid;

  // Period timing and watchdog.
  logic        period_tick;
  logic        ramp_step;
  logic [7:0]  div_cnt;
  logic [15:0] wdt_cnt;
  logic        wdt_fire;

  // Per-channel duty state.
  logic [7:0]  target   [NUM_CH];
  logic [7:0]  cur      [NUM_CH];
  logic [7:0]  cur_next [NUM_CH];

  // One ramp step from cur toward tgt. Both branches work on 9-bit
  // differences, so the result lands on tgt exactly and never wraps.
  function automatic logic [7:0] ramp_next(input logic [7:0] cur_v,
                                           input logic [7:0] tgt_v);
    logic [8:0] diff;
    logic [8:0] moved;
    if (tgt_v >= cur_v) begin
      diff  = {1'b0, tgt_v} - {1'b0, cur_v};
      moved = {1'b0, cur_v} + STEP9;
    end else begin
      diff  = {1'b0, cur_v} - {1'b0, tgt_v};
      moved = {1'b0, cur_v} - STEP9;
    end
    // When diff > STEP the moved value stays strictly between cur and
    // tgt, so its ninth bit is always zero here.
    if (diff <= STEP9) begin
      return tgt_v;
    end
    return moved[7:0];
  endfunction

  // Bring SSEL into the clk25M domain and keep one delayed copy for edge detect.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the
  // synchronizer chain into a single flop.
  always_ff @(posedge clk25M or negedge rst_n) begin
    if (!rst_n) begin
      ssel_meta <= 1'b0;
      ssel_sync <= 1'b0;
      ssel_dly  <= 1'b0;
    end else begin
      ssel_meta <= SSEL;
      ssel_sync <= ssel_meta;
      ssel_dly  <= ssel_sync;
    end
  end

  // A held-high SSEL yields exactly one event: the synchronized rising edge.
  assign pkt_evt     = ssel_sync & ~ssel_dly;
  assign pkt_addr    = byte_data_received[15:8];
  assign pkt_duty    = byte_data_received[7:0];
  assign addr_is_ch  = (pkt_addr != 8'h00) && (pkt_addr <= ADDR_MAX);
  assign addr_is_all = (pkt_addr == ADDR_ALL);
  assign pkt_valid   = pkt_evt & (addr_is_ch | addr_is_all);

  // Flag packets whose address maps to nothing, for one cycle.
  always_ff @(posedge clk25M or negedge rst_n) begin
    if (!rst_n) begin
      pkt_err <= 1'b0;
    end else begin
      pkt_err <= pkt_evt & ~(addr_is_ch | addr_is_all);
    end
  end

  // Free-running period counter; wraps naturally at 8 bits.
  always_ff @(posedge clk25M or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= 8'd0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  assign period_tick = (pwm_cnt == 8'hFF);
  assign ramp_step   = period_tick && (div_cnt == DIV_LAST);

  // Divide period ticks down to ramp steps.
  always_ff @(posedge clk25M or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= 8'd0;
    end else if (period_tick) begin
      div_cnt <= (div_cnt == DIV_LAST) ? 8'd0 : div_cnt + 8'd1;
    end
  end

  // The trip fires on the tick that takes the counter to WDT_PERIODS; a
  // packet in the same cycle wins and suppresses it.
  assign wdt_fire = WDT_EN && period_tick && (wdt_cnt == WDT_LAST) && !pkt_valid;

  // Count silent periods since the last valid packet, saturating at the limit.
  always_ff @(posedge clk25M or negedge rst_n) begin
    if (!rst_n) begin
      wdt_cnt     <= 16'd0;
      wdt_tripped <= 1'b0;
    end else if (pkt_valid) begin
      wdt_cnt     <= 16'd0;
      wdt_tripped <= 1'b0;
    end else if (WDT_EN && period_tick && (wdt_cnt != WDT_PERIODS)) begin
      wdt_cnt <= wdt_cnt + 16'd1;
      if (wdt_fire) begin
        wdt_tripped <= 1'b1;
      end
    end
  end

  // Update targets from packets, or load the failsafe pattern on a trip.
  // NOTE: the target array is a handful of flops, not a RAM, so every
  // entry gets an explicit reset value; a real memory macro would not.
  always_ff @(posedge clk25M or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        target[i] <= 8'd0;
      end
    end else if (pkt_valid) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (addr_is_all || (pkt_addr == 8'(i + 1))) begin
          target[i] <= pkt_duty;
        end
      end
    end else if (wdt_fire) begin
      for (int i = 0; i < NUM_CH; i++) begin
        target[i] <= (i == VENT_CH) ? 8'hFF : 8'h00;
      end
    end
  end

  // Next live duty per channel, always from the currently held target.
  // NOTE: combinational blocks assign every output on every path (here the
  // loop covers all channels unconditionally), otherwise a latch is inferred.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cur_next[i] = ramp_next(cur[i], target[i]);
    end
  end

  // Live duties move only on the ramp-step tick edge, so each new value first
  // compares against pwm_cnt == 0 and no period is cut short.
  always_ff @(posedge clk25M or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cur[i] <= 8'd0;
      end
    end else if (ramp_step) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cur[i] <= cur_next[i];
      end
    end
  end

  // Registered comparators: duty 0 never drives high, duty 255 is high 255/256.
  always_ff @(posedge clk25M or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        pwm_out[i] <= (cur[i] > pwm_cnt);
      end
    end
  end

  // Flatten live duties onto the output bus, channel i at [8i+7:8i].
  for (genvar g = 0; g < NUM_CH; g++) begin : g_duty_bus
    assign duty_cur[8*g +: 8] = cur[g];
  end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Directed bench for pwm_duty_sequencer. Four channels, STEP 16,
// RAMP_DIV 2, watchdog after 20 silent periods. Expected live-duty words are
// queued when a packet or trip is set up and popped on each ramp-step edge.

module tb_pwm_duty_sequencer;

  logic        clk25M = 1'b0;
  logic        rst_n;
  logic [15:0] byte_data_received;
  logic        SSEL;
  logic [7:0]  pwm_cnt;
  logic [31:0] duty_cur;
  logic [3:0]  pwm_out;
  logic        wdt_tripped;
  logic        pkt_err;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;      // edges since the last reset release
  logic [31:0] exp_q[$];         // expected duty_cur words, one per ramp step
  logic [31:0] last_exp = 32'd0; // duty_cur expected to hold between steps

  pwm_duty_sequencer #(
    .NUM_CH      (4),
    .STEP        (16),
    .RAMP_DIV    (2),
    .WDT_PERIODS (16'd20),
    .VENT_CH     (0)
  ) dut (
    .clk25M             (clk25M),
    .rst_n              (rst_n),
    .byte_data_received (byte_data_received),
    .SSEL               (SSEL),
    .pwm_cnt            (pwm_cnt),
    .duty_cur           (duty_cur),
    .pwm_out            (pwm_out),
    .wdt_tripped        (wdt_tripped),
    .pkt_err            (pkt_err)
  );

  always #20 clk25M = ~clk25M;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk25M);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) tick();
  endtask

  // Ramp step m lands on the edge ending period m (edge 256*m).
  task automatic ramp_check(input int m);
    logic [31:0] e;
    run_to(256 * m - 1);
    check($sformatf("hold_before_m%0d", m), duty_cur, last_exp);
    tick();
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check($sformatf("ramp_m%0d", m), duty_cur, e);
    last_exp = e;
  endtask

  // Drive one packet, hold SSEL for 'hold' clocks, then low for 4 clocks.
  // pkt_err must appear exp_err times, the first on the third edge.
  task automatic send(input logic [15:0] data, input int hold, input int exp_err,
                      input string tag);
    int errs;
    int first;
    errs  = 0;
    first = -1;
    byte_data_received = data;
    SSEL = 1'b1;
    for (int i = 1; i <= hold + 4; i++) begin
      if (i == hold + 1) SSEL = 1'b0;
      tick();
      if (pkt_err === 1'b1) begin
        errs++;
        if (first < 0) first = i;
      end
    end
    check({tag, "_err_count"}, 32'(errs), 32'(exp_err));
    if (exp_err != 0) check({tag, "_err_edge"}, 32'(first), 32'd3);
  endtask

  initial begin
    int nz;
    int hi0;
    int hi1;

    rst_n = 1'b0;
    SSEL = 1'b0;
    byte_data_received = 16'h0000;
    repeat (3) @(posedge clk25M);
    #1;
    check("rst_pwm_cnt",  32'(pwm_cnt), 32'd0);
    check("rst_duty_cur", duty_cur,     32'd0);
    check("rst_pwm_out",  32'(pwm_out), 32'd0);
    check("rst_wdt",      32'(wdt_tripped), 32'd0);
    check("rst_pkt_err",  32'(pkt_err), 32'd0);
    rst_n = 1'b1;
    cyc = 0;

    // Idle first period: outputs low, counter wraps on clock 256.
    nz = 0;
    repeat (256) begin
      tick();
      if (pwm_out != 4'd0) nz++;
      if (cyc == 255) check("cnt_255", 32'(pwm_cnt), 32'hFF);
    end
    check("cnt_wrap", 32'(pwm_cnt), 32'd0);
    check("idle_pwm_low", 32'(nz), 32'd0);

    // Channel 1 to 0x40: four steps of 16, one every two periods.
    run_to(260);
    exp_q.push_back(32'h0000_1000);
    exp_q.push_back(32'h0000_2000);
    exp_q.push_back(32'h0000_3000);
    exp_q.push_back(32'h0000_4000);
    send(16'h0240, 4, 0, "ch1");
    for (int m = 2; m <= 8; m += 2) ramp_check(m);

    // One full period at duty 0x40: high on compares 0..63 only.
    hi0 = 0;
    hi1 = 0;
    repeat (256) begin
      tick();
      if (pwm_out[0]) hi0++;
      if (pwm_out[1]) hi1++;
    end
    check("pwm1_high_count", 32'(hi1), 32'd64);
    check("pwm0_high_count", 32'(hi0), 32'd0);

    // Undefined addresses: error pulse only, nothing else moves.
    run_to(2310);
    send(16'h0005, 4, 1, "addr00");
    send(16'h0733, 4, 1, "addr07");
    check("bad_addr_duty", duty_cur, 32'h0000_4000);
    check("bad_addr_wdt",  32'(wdt_tripped), 32'd0);

    // Last valid packet cleared the watchdog on edge 263, so the 20th
    // silent tick is period 21 (edge 5376).
    run_to(5375);
    check("wdt_pre_trip", 32'(wdt_tripped), 32'd0);
    tick();
    check("wdt_trip", 32'(wdt_tripped), 32'd1);
    exp_q.push_back(32'h0000_3010);
    exp_q.push_back(32'h0000_2020);
    exp_q.push_back(32'h0000_1030);
    exp_q.push_back(32'h0000_0040);
    for (int m = 22; m <= 28; m += 2) ramp_check(m);
    check("wdt_saturated", 32'(wdt_tripped), 32'd1);

    // Broadcast 0x80 clears the trip and ramps every channel to 0x80.
    run_to(7170);
    exp_q.push_back(32'h1010_1050);
    exp_q.push_back(32'h2020_2060);
    exp_q.push_back(32'h3030_3070);
    exp_q.push_back(32'h4040_4080);
    exp_q.push_back(32'h5050_5080);
    exp_q.push_back(32'h6060_6080);
    exp_q.push_back(32'h7070_7080);
    exp_q.push_back(32'h8080_8080);
    exp_q.push_back(32'h8080_8080);
    send(16'hFF80, 4, 0, "bcast");
    check("wdt_clear", 32'(wdt_tripped), 32'd0);
    for (int m = 30; m <= 46; m += 2) ramp_check(m);

    // SSEL held for 1000 clocks: one write of channel 0 to 0x11.
    run_to(11780);
    send(16'h0111, 1000, 0, "hold_valid");
    check("held_write", duty_cur, 32'h8080_8070);
    last_exp = 32'h8080_8070;
    exp_q.push_back(32'h8080_8060);
    exp_q.push_back(32'h8080_8050);
    for (int m = 50; m <= 52; m += 2) ramp_check(m);

    // Held bad packet: exactly one error pulse, watchdog still idle.
    run_to(13320);
    send(16'h0005, 1000, 1, "hold_bad");
    check("hold_bad_wdt", 32'(wdt_tripped), 32'd0);
    check("mid_ramp_duty", duty_cur, 32'h8080_8040);

    // Reset mid-ramp clears everything without waiting for a clock.
    run_to(14400);
    rst_n = 1'b0;
    #5;
    check("mid_rst_pwm_cnt", 32'(pwm_cnt), 32'd0);
    check("mid_rst_duty",    duty_cur,     32'd0);
    check("mid_rst_pwm_out", 32'(pwm_out), 32'd0);
    check("mid_rst_wdt",     32'(wdt_tripped), 32'd0);
    @(posedge clk25M);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    run_to(513);
    check("post_rst_duty", duty_cur, 32'd0);
    check("post_rst_cnt",  32'(pwm_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_duty_sequencer.md
# pwm_duty_sequencer

Control block for the PWM channel bank: decodes 16-bit address/duty packets delivered by the SPI receiver with SSEL, holds one target duty per channel, and ramps each live duty toward its target at PWM period boundaries. It owns the shared 8-bit PWM period counter and drives the per-channel comparator outputs. A period-based watchdog forces a failsafe duty pattern (vent channel full on, others off) when the SPI master goes silent.

## Interface
- NUM_CH, 4, number of PWM channels; packet addresses 1..NUM_CH map to channels 0..NUM_CH-1.
- STEP, 1, duty change per ramp step (1..255).
- RAMP_DIV, 1, PWM periods per ramp step (1..256).
- WDT_PERIODS, 16'd6104, PWM periods without a valid packet before failsafe (≈62.5 ms at 25 MHz); 0 disables the watchdog.
- VENT_CH, 0, channel forced to 8'hFF in failsafe.
- clk25M  in  1  system clock, 25 MHz.
- rst_n  in  1  asynchronous active-low reset.
- byte_data_received  in  16  packet: [15:8] address, [7:0] duty; stable while SSEL is high.
- SSEL  in  1  packet-valid level from the SPI receiver, asynchronous to clk25M.
- pwm_cnt  out  8  free-running PWM period counter.
- duty_cur  out  8*NUM_CH  live duty per channel; channel i is at [8i+7:8i].
- pwm_out  out  NUM_CH  registered PWM outputs.
- wdt_tripped  out  1  failsafe active.
- pkt_err  out  1  one-cycle pulse on a packet with an undefined address.

## Operation
- SSEL passes through a 2-flop synchronizer plus a delay flop. A packet event is the synchronized rising edge. One event is generated per SSEL high pulse; held-high SSEL does not re-trigger.
- Address decode on an event:
  - 1..NUM_CH: target[addr-1] <= duty.
  - 8'hFF: all targets <= duty.
  - 8'h00 or any other value: no target change; pkt_err pulses for 1 cycle.
- Valid packets (1..NUM_CH, 8'hFF) clear the watchdog counter and clear wdt_tripped.
- pwm_cnt increments every clock and wraps 255→0. The period tick is the cycle with pwm_cnt == 255.
- Ramp divider counts period ticks from 0 to RAMP_DIV-1. On the tick where it equals RAMP_DIV-1, the divider returns to 0 and each channel updates:
  - If |target-cur| <= STEP: cur <= target.
  - Otherwise cur moves by STEP toward target.
  - Use 9-bit difference arithmetic; cur never overshoots or wraps.
- duty_cur changes only on that tick edge, so a new duty first takes effect at pwm_cnt == 0. This keeps PWM periods glitch-free.
- pwm_out[i] is registered each clock as (duty_cur[i] > pwm_cnt):
  - duty 0: output constantly low.
  - duty 255: output high 255/256 of the period.
- Watchdog (WDT_PERIODS != 0):
  - Counts period ticks since the last valid packet, saturating at WDT_PERIODS.
  - On reaching WDT_PERIODS: wdt_tripped <= 1, target[VENT_CH] <= 8'hFF, all other targets <= 0.
  - Ramping then proceeds normally toward the failsafe targets.
- Simultaneous events:
  - Packet and watchdog trip in the same cycle: the packet wins, no trip occurs, and the counter clears.
  - Packet and ramp tick in the same cycle: the ramp uses the old target; the new target is used from the next step.
- Reset assertion mid-operation immediately returns all state to reset values, regardless of ramp or packet progress.

## Timing
- Reset values: pwm_cnt 0, all targets 0, duty_cur 0, pwm_out 0, wdt_tripped 0, pkt_err 0, synchronizer flops 0, divider and watchdog counters 0.
- Packet latency: SSEL first sampled high at edge k → target (or pkt_err) updated at edge k+2. pkt_err is high for exactly the cycle after edge k+2.
- Ramp latency: duty_cur is updated at the edge ending the pwm_cnt == 255 cycle. pwm_out reflects the new duty one clock later, i.e. from the pwm_cnt == 0 compare onward.
- Full ramp from 0 to T takes ceil(T/STEP)*RAMP_DIV periods; each period is 256 clocks.
- Watchdog trip: wdt_tripped rises at the period tick edge on which the counter reaches WDT_PERIODS.

## Test plan
- Reset release, no packets, WDT_PERIODS=0 → pwm_out all 0 for 1024 clocks; pwm_cnt wraps 255→0 at clock 256.
- Packet 16'h0240, STEP=255 → target[1]=0x40 at k+2; duty_cur[1]=0x40 at the next wrap; pwm_out[1] high for exactly 64 of each 256 clocks.
- STEP=16, RAMP_DIV=2, packet 16'hFF80 → every duty_cur steps 0x10, 0x20, …, 0x80, advancing every 2 periods and reaching 0x80 after 16 periods; no overshoot.
- Packets 16'h0005 and 16'h0733 with NUM_CH=4 → pkt_err pulses once each; no target, duty_cur, or watchdog state changes.
- WDT_PERIODS=4, STEP=255, packet 16'h0120 then silence → wdt_tripped rises at the 4th period tick; duty_cur[0]=0xFF and others 0 after the next tick. Packet 16'h0210 then clears wdt_tripped and sets target[1]=0x10.
- SSEL held high for 1000 clocks with 16'h0111 → exactly one target write; rst_n pulsed low mid-ramp → all outputs return to 0 immediately.
